// File: rtl/seg7_scan_n_if.sv
// Bundle between the display mux / port registers and the seg7_scan_n scan driver.
// Level-sampled inputs, registered outputs; no handshake. dbg_* expose the scan position.
interface seg7_scan_n_if #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int PWM_BITS = 4
) ();
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] di;
  logic [8*DIGITS-1:0] pixels;
  logic                direct;
  logic [DIGITS-1:0]   dp;
  logic                blank_lz;
  logic [PWM_BITS-1:0] brightness;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame_tick;
  logic [PW-1:0]       dbg_pre;
  logic [IW-1:0]       dbg_idx;

  modport master (
    output di, pixels, direct, dp, blank_lz, brightness,
    input  seg, an, frame_tick, dbg_pre, dbg_idx
  );

  modport slave (
    input  di, pixels, direct, dp, blank_lz, brightness,
    output seg, an, frame_tick, dbg_pre, dbg_idx
  );
endinterface

// File: rtl/seg7_scan_n.sv
// N-digit multiplexed 7-segment scan driver with frame-coherent input snapshot,
// leading-zero blanking, ghost blanking and optional brightness PWM (SEG7_SCAN_PWM_EN).
module seg7_scan_n #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int PWM_BITS = 4
) (
  input  logic         clk,
  input  logic         reset,
  seg7_scan_n_if.slave bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  logic [PW-1:0]       pre;
  logic [IW-1:0]       idx;
  logic                primed;
  logic                slot_end, frame_end, take_snap, lamp_on;
  logic [4*DIGITS-1:0] snap_di;
  logic [8*DIGITS-1:0] snap_pixels;
  logic [DIGITS-1:0]   snap_dp;
  logic                snap_direct, snap_blank_lz;
  logic [7:0]          seg_q, seg_next, pix;
  logic [DIGITS-1:0]   an_q, an_next;
  logic                tick_q;
  logic [3:0]          nib;
  logic                dp_bit, lz_run, blank_digit;

  assign slot_end  = (pre == PRE_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  // The snapshot taken on a frame_end edge is what digit 0 of the new frame shows.
  assign take_snap = !primed || frame_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre    <= '0;
      idx    <= '0;
      primed <= 1'b0;
    end else begin
      primed <= 1'b1;
      if (slot_end) begin
        pre <= '0;
        idx <= frame_end ? '0 : idx + IW'(1);
      end else begin
        pre <= pre + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_di       <= '0;
      snap_pixels   <= '0;
      snap_dp       <= '0;
      snap_direct   <= 1'b0;
      snap_blank_lz <= 1'b0;
    end else if (take_snap) begin
      snap_di       <= bus.di;
      snap_pixels   <= bus.pixels;
      snap_dp       <= bus.dp;
      snap_direct   <= bus.direct;
      snap_blank_lz <= bus.blank_lz;
    end
  end

`ifdef SEG7_SCAN_PWM_EN
  logic [PWM_BITS-1:0] pwm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm <= '0;
    else       pwm <= pwm + PWM_BITS'(1);
  end

  assign lamp_on = (pwm <= bus.brightness);
`else
  logic unused_brightness;
  assign unused_brightness = ^bus.brightness;
  assign lamp_on = 1'b1;
`endif

  // lz_run walks from the top digit down: true while every nibble so far is zero.
  always_comb begin
    nib         = '0;
    pix         = '0;
    dp_bit      = 1'b0;
    lz_run      = 1'b1;
    blank_digit = 1'b0;
    seg_next    = '0;
    an_next     = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz_run = lz_run && (snap_di[4*k +: 4] == 4'h0);
      if (idx == IW'(k)) begin
        nib         = snap_di[4*k +: 4];
        pix         = snap_pixels[8*k +: 8];
        dp_bit      = snap_dp[k];
        blank_digit = lz_run && (k != 0);
      end
    end
    if (snap_direct) seg_next = pix;
    else             seg_next = {dp_bit, (snap_blank_lz && blank_digit) ? 7'h00 : hex_glyph(nib)};
    for (int k = 0; k < DIGITS; k++) begin
      an_next[k] = (idx == IW'(k)) && (pre != '0) && lamp_on;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q  <= '0;
      an_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      seg_q  <= seg_next;
      an_q   <= an_next;
      tick_q <= frame_end;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = tick_q;
  assign bus.dbg_pre    = pre;
  assign bus.dbg_idx    = idx;
endmodule

// File: tb/tb_seg7_scan_n.sv
// Bench for seg7_scan_n: cycle-level reference model plus directed and randomized steps.
`timescale 1ns/1ps
module tb_seg7_scan_n;
  localparam int D     = 4;
  localparam int PA    = 4;
  localparam int PB    = 64;
  localparam int PWB   = 4;
  localparam int FRAME = PA * D;
`ifdef SEG7_SCAN_PWM_EN
  localparam bit PWM_EN = 1'b1;
`else
  localparam bit PWM_EN = 1'b0;
`endif
  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_n_if #(.DIGITS(D), .PRESCALE(PA), .PWM_BITS(PWB)) bus_a ();
  seg7_scan_n_if #(.DIGITS(D), .PRESCALE(PB), .PWM_BITS(PWB)) bus_b ();

  seg7_scan_n #(.DIGITS(D), .PRESCALE(PA), .PWM_BITS(PWB)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  seg7_scan_n #(.DIGITS(D), .PRESCALE(PB), .PWM_BITS(PWB)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  // reference model: n = clk edges since reset release; frame snapshot held in m_*
  int          n = 0;
  logic [15:0] m_di;
  logic [31:0] m_pix;
  logic [3:0]  m_dp;
  logic        m_direct, m_blank;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_tick;
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cnt_b = 0;

  function automatic logic [7:0] model_seg(input int dig);
    logic [31:0] sh;
    logic [15:0] upper;
    logic        blank;
    if (m_direct) begin
      sh = m_pix >> (8 * dig);
      return sh[7:0];
    end
    upper = m_di >> (4 * dig);
    blank = m_blank && (dig > 0) && (upper == 16'h0);
    return {m_dp[dig], blank ? 7'h00 : GLYPH[upper[3:0]]};
  endfunction

  always @(posedge clk or posedge reset) begin
    int s, dig, pre_m;
    logic on;
    if (reset) begin
      n = 0; m_di = '0; m_pix = '0; m_dp = '0; m_direct = 1'b0; m_blank = 1'b0;
      exp_seg = '0; exp_an = '0; exp_tick = 1'b0;
    end else begin
      n = n + 1;
      s = n - 1;
      pre_m = s % PA;
      dig = (s / PA) % D;
      on = PWM_EN ? ((s % (1 << PWB)) <= int'(bus_a.brightness)) : 1'b1;
      exp_seg = model_seg(dig);
      exp_an = (pre_m != 0 && on) ? 4'(1 << dig) : 4'h0;
      exp_tick = (n % FRAME) == 0;
      if (n == 1 || (n % FRAME) == 0) begin
        m_di = bus_a.di; m_pix = bus_a.pixels; m_dp = bus_a.dp;
        m_direct = bus_a.direct; m_blank = bus_a.blank_lz;
      end
    end
  end

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_inputs(input logic [15:0] di, input logic [31:0] pix, input logic [3:0] dp,
                            input logic direct, input logic blank, input logic [3:0] bright);
    bus_a.di = di; bus_a.pixels = pix; bus_a.dp = dp;
    bus_a.direct = direct; bus_a.blank_lz = blank; bus_a.brightness = bright;
  endtask

  task automatic step();
    @(negedge clk);
    check("seg", 32'(bus_a.seg), 32'(exp_seg));
    check("an", 32'(bus_a.an), 32'(exp_an));
    check("frame_tick", 32'(bus_a.frame_tick), 32'(exp_tick));
    if (bus_b.an != '0) cnt_b++;
  endtask

  task automatic wait_frame_start();
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME + 4 && !found; i++) begin
      step();
      if ((n % FRAME) == 0) found = 1'b1;
    end
    check("wait_frame", 32'(found), 32'd1);
  endtask

  task automatic wait_slot(input int digit, input int pre_v);
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME + 4 && !found; i++) begin
      step();
      if (((n - 1) % FRAME) == digit * PA + pre_v) found = 1'b1;
    end
    check("wait_slot", 32'(found), 32'd1);
  endtask

  task automatic slot_seg(input string tag, input int digit, input logic [7:0] seg_exp);
    wait_slot(digit, 1);
    check(tag, 32'(bus_a.seg), 32'(seg_exp));
  endtask

  task automatic measure_b(output int cnt);
    bit found = 1'b0;
    for (int i = 0; i < 2 * PB + 4 && !found; i++) begin
      step();
      if ((n % PB) == 0) found = 1'b1;
    end
    check("wait_pwm_slot", 32'(found), 32'd1);
    cnt_b = 0;
    repeat (PB) step();
    cnt = cnt_b;
  endtask

  function automatic int pwm_expect(input int b);
    int c = 0;
    for (int j = 0; j < PB; j++) if (j != 0 && (!PWM_EN || (j % (1 << PWB)) <= b)) c++;
    return c;
  endfunction

  initial begin
    int cnt, ticks;
    set_inputs(16'h1234, 32'h0, 4'h0, 1'b0, 1'b0, 4'hF);
    bus_b.di = '0; bus_b.pixels = '0; bus_b.dp = '0;
    bus_b.direct = 1'b0; bus_b.blank_lz = 1'b0; bus_b.brightness = 4'hF;

    #1 reset = 1'b1;
    #1;
    check("rst_seg", 32'(bus_a.seg), 32'h0);
    check("rst_an", 32'(bus_a.an), 32'h0);
    check("rst_tick", 32'(bus_a.frame_tick), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rel_pre", 32'(bus_a.dbg_pre), 32'h0);
    check("rel_idx", 32'(bus_a.dbg_idx), 32'h0);

    // scan order, glyphs, tick rate
    wait_frame_start();
    wait_slot(0, 0);
    check("ghost_d0", 32'(bus_a.an), 32'h0);
    wait_slot(0, 1);
    check("an_d0", 32'(bus_a.an), 32'h1);
    check("seg_d0_4", 32'(bus_a.seg), 32'h66);
    slot_seg("seg_d1_3", 1, 8'h4F);
    wait_slot(2, 0);
    check("ghost_d2", 32'(bus_a.an), 32'h0);
    wait_slot(2, 3);
    check("an_d2", 32'(bus_a.an), 32'h4);
    slot_seg("seg_d3_1", 3, 8'h06);
    check("an_d3", 32'(bus_a.an), 32'h8);
    ticks = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (bus_a.frame_tick) ticks++;
    end
    check("tick_count", 32'(ticks), 32'd2);

    // frame coherence
    wait_frame_start();
    wait_slot(1, 2);
    bus_a.di = 16'h5678;
    slot_seg("coh_d2_old", 2, 8'h5B);
    slot_seg("coh_d3_old", 3, 8'h06);
    slot_seg("coh_d0_new", 0, 8'h7F);
    slot_seg("coh_d1_new", 1, 8'h07);
    slot_seg("coh_d2_new", 2, 8'h7D);
    slot_seg("coh_d3_new", 3, 8'h6D);

    // leading-zero blanking
    set_inputs(16'h0040, 32'h0, 4'b0100, 1'b0, 1'b1, 4'hF);
    wait_frame_start();
    slot_seg("lz_d0", 0, 8'h3F);
    slot_seg("lz_d1", 1, 8'h66);
    slot_seg("lz_d2", 2, 8'h80);
    slot_seg("lz_d3", 3, 8'h00);
    set_inputs(16'h0000, 32'h0, 4'b0000, 1'b0, 1'b1, 4'hF);
    wait_frame_start();
    slot_seg("lz0_d0", 0, 8'h3F);
    slot_seg("lz0_d1", 1, 8'h00);
    slot_seg("lz0_d2", 2, 8'h00);
    slot_seg("lz0_d3", 3, 8'h00);

    // direct mode
    set_inputs(16'h0000, 32'hFF00AA55, 4'hF, 1'b1, 1'b1, 4'hF);
    wait_frame_start();
    slot_seg("dir_d0", 0, 8'h55);
    slot_seg("dir_d1", 1, 8'hAA);
    slot_seg("dir_d2", 2, 8'h00);
    slot_seg("dir_d3", 3, 8'hFF);

    // brightness duty on the long-slot instance
    bus_b.brightness = 4'd3;
    measure_b(cnt);
    check("pwm_b3", 32'(cnt), 32'(pwm_expect(3)));
    bus_b.brightness = 4'd0;
    measure_b(cnt);
    check("pwm_b0", 32'(cnt), 32'(pwm_expect(0)));
    bus_b.brightness = 4'hF;
    measure_b(cnt);
    check("pwm_bF", 32'(cnt), 32'(pwm_expect(15)));

    // randomized inputs against the model
    for (int r = 0; r < 12; r++) begin
      set_inputs($urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 255)), $urandom,
                 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
      repeat ($urandom_range(3, 30)) step();
    end

    // async reset mid-slot
    set_inputs(16'h8888, 32'h0, 4'h0, 1'b0, 1'b0, 4'hF);
    wait_frame_start();
    wait_slot(2, 2);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_seg", 32'(bus_a.seg), 32'h0);
    check("mid_rst_an", 32'(bus_a.an), 32'h0);
    check("mid_rst_tick", 32'(bus_a.frame_tick), 32'h0);
    check("mid_rst_pre", 32'(bus_a.dbg_pre), 32'h0);
    check("mid_rst_idx", 32'(bus_a.dbg_idx), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    check("mid_rel_pre", 32'(bus_a.dbg_pre), 32'h0);
    check("mid_rel_idx", 32'(bus_a.dbg_idx), 32'h0);
    repeat (2 * FRAME + 3) step();

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/seg7_scan_n.md
Name: seg7_scan_n

Overview:
- Parametrised N-digit multiplexed 7-segment scan driver; successor to the fixed 4-digit driver used on board tops.
- Adds per-digit decimal points, leading-zero blanking, inter-digit ghost blanking, frame-coherent input snapshot, and brightness PWM.
- Sits between the display mux / port registers and the board SEG/AN pins.
- Outputs are active-high; the board top inverts them where needed.

Parameters:
- DIGITS, 4, number of digits scanned (1..16).
- PRESCALE, 1000, clk cycles per digit slot (>=4).
- PWM_BITS, 4, width of the brightness control.

Ports:
- clk  in  1  scan clock (typically f1MHz).
- reset  in  1  asynchronous, active-high reset.
- di  in  4*DIGITS  hex nibbles; nibble k drives digit k; digit 0 is least significant / rightmost.
- pixels  in  8*DIGITS  raw segment bytes for direct mode; byte k drives digit k.
- direct  in  1  1 = display pixels bytes, 0 = hex-decode di.
- dp  in  DIGITS  decimal point per digit (hex mode only).
- blank_lz  in  1  enable leading-zero blanking (hex mode only).
- brightness  in  PWM_BITS  duty control.
- seg  out  8  segments; bit0=a … bit6=g, bit7=dp; active-high.
- an  out  DIGITS  one-hot digit enable; active-high.
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

Behaviour:
- Reset (async): clears all internal state.
  - pre, idx and pwm are 0; snapshot registers are 0; primed is 0.
  - Outputs: seg=0, an=0, frame_tick=0.
  - Reset asserted mid-frame forces these values immediately, without waiting for a clk edge.
- Prescaler pre:
  - Counts 0..PRESCALE-1 and wraps.
  - On wrap, idx advances by 1; from DIGITS-1 it wraps to 0.
- Snapshot: di, pixels, dp, direct and blank_lz are registered at two points, so a frame never mixes two input values:
  - on the first clk edge after reset (primed goes 0→1);
  - on the edge where pre=PRESCALE-1 and idx=DIGITS-1.
- frame_tick: registered; high for exactly the one cycle following the idx wrap DIGITS-1→0.
- Hex decode (standard 0-F glyphs), e.g. 0→0x3F, 1→0x06, 8→0x7F, A→0x77, F→0x71.
  - seg[7] = snapshot dp[idx].
- Leading-zero blanking (blank_lz=1, direct=0):
  - Digit k is blanked when nibbles DIGITS-1..k are all zero and k>0.
  - Digit 0 is never blanked.
  - In a blanked digit, seg[6:0]=0 but seg[7] still follows dp[k].
- Direct mode: seg = snapshot pixels[8*idx+7 : 8*idx]. dp and blank_lz are ignored.
- Ghost blank: when pre=0, an=0 (all digits dark for one cycle per slot).
- PWM:
  - Free-running PWM_BITS counter pwm increments every clk.
  - The digit is on when pwm <= brightness.
  - brightness = all-ones gives full duty (except the ghost cycle); brightness = 0 gives 1/2^PWM_BITS duty.
- Output timing:
  - seg and an are registered: one clk latency from pre/idx state.
  - an = (1 << idx) when enabled, else 0.
  - seg is driven even while an=0.
- Simultaneous snapshot and idx wrap on the same edge: the new snapshot applies to digit 0 of the new frame.

Optional Feature:
- Macro: SEG7_SCAN_PWM_EN.
- Defined: PWM counter and brightness gating are implemented as described above.
- Undefined:
  - No pwm counter; the brightness port is present but ignored.
  - an is enabled for every cycle of a slot except the ghost cycle (pre=0).

Test Plan:
- Reset / async clear: DIGITS=4, PRESCALE=4; assert reset mid-slot with no clk edge → seg=0, an=0, frame_tick=0 immediately. After release, pre=0, idx=0.
- Scan order and tick: DIGITS=4, PRESCALE=4, brightness=F, di=0x1234.
  - an sequence per 4-cycle slot is 0,1,1,1 (×0001), then 0,2,2,2, 0,4,4,4, 0,8,8,8.
  - seg for digit 0 = 0x66 ('4'); digit 3 = 0x06 ('1').
  - frame_tick pulses once every 16 cycles.
- Frame coherence: change di from 0x1234 to 0x5678 during the slot of digit 1 → digits 2 and 3 still show 2 and 1; next frame shows 8,7,6,5.
- Leading-zero blanking: di=0x0040, dp=4'b0100, blank_lz=1.
  - Digit 3: seg=0x00.
  - Digit 2: seg=0x80.
  - Digit 1: seg=0x66.
  - Digit 0: seg=0x3F.
  - With di=0x0000, only digit 0 shows 0x3F.
- Direct mode: direct=1, pixels=0xFF_00_AA_55 → digit 0 seg=0x55, digit 1 seg=0xAA, digit 3 seg=0xFF; dp and blank_lz have no effect.
- PWM (SEG7_SCAN_PWM_EN defined): PRESCALE=64, brightness=3 → an is high in 16 of 64 cycles per slot, ±1 for the ghost cycle. brightness=0 → 4 of 64. With the macro undefined → 63 of 64 for any brightness.
